// File: rtl/cnu_serial_pkg.sv
// cnu_serial_pkg: shared constants and types for the serial check node unit.
//   CNU_DATA_W  : message width (two's complement), shared with the VN stage
//   CNU_DC      : check node degree (messages per row)
//   CNU_IDX_W   : width of an edge index within a row
//   CNU_MAG_MAX : saturated maximum magnitude, 2^(DATA_W-1)-1
//   state_e     : CNU control FSM states
package cnu_serial_pkg;

  localparam int CNU_DATA_W  = 8;
  localparam int CNU_DC      = 6;
  localparam int CNU_IDX_W   = $clog2(CNU_DC);
  localparam int CNU_MAG_MAX = (2 ** (CNU_DATA_W - 1)) - 1;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_EMIT    = 1'b1
  } state_e;

endpackage : cnu_serial_pkg

// File: rtl/cnu_serial_satmag.sv
// satmag: combinational absolute value with saturation.
//   din : signed two's complement input, DATA_W bits
//   mag : |din| as an unsigned DATA_W-bit value; the most negative input
//         maps to 2^(DATA_W-1)-1 so the result always fits in DATA_W-1 bits
module satmag #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] mag
);

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAG_MAX  = {1'b0, {(DATA_W-1){1'b1}}};

  always_comb begin
    mag = din;
    if (din[DATA_W-1]) begin
      if (din == MOST_NEG) begin
        mag = MAG_MAX;
      end else begin
        mag = (~din) + DATA_W'(1);
      end
    end
  end

endmodule : satmag

// File: rtl/cnu_serial.sv
// cnu_serial: serial offset min-sum check node unit.
// Collects DC variable-to-check messages one per transfer, tracking the two
// smallest magnitudes, the index of the smallest, every sign bit and the row
// parity. Then emits DC check-to-variable messages in edge order.
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid/in_ready/in_q : input message stream (signed)
//   out_valid/out_ready    : output handshake
//   out_r                  : check-to-variable message (signed)
//   out_idx                : edge index of out_r
//   out_parity             : XOR of all input sign bits of the row
module cnu_serial
  import cnu_serial_pkg::*;
#(
  parameter int DATA_W = CNU_DATA_W,
  parameter int DC     = CNU_DC,
  parameter int OFFSET = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_r,
  output logic [$clog2(DC)-1:0] out_idx,
  output logic                  out_parity
);

  localparam int                IDX_W   = $clog2(DC);
  localparam logic [DATA_W-1:0] MAG_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] OFF     = DATA_W'(OFFSET);
  localparam logic [IDX_W-1:0]  K_LAST  = IDX_W'(DC - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      k_q, k_d;
  logic [DATA_W-1:0]     min1_q, min1_d;
  logic [DATA_W-1:0]     min2_q, min2_d;
  logic [IDX_W-1:0]      idx1_q, idx1_d;
  logic                  parity_q, parity_d;
  logic [DC-1:0]         sign_q, sign_d;

  logic [DATA_W-1:0]     in_mag;
  logic                  collect, emit;
  logic                  in_fire, out_fire;
  logic                  sign_sel;
  logic [DATA_W-1:0]     m_sel;
  logic [DATA_W-1:0]     mag_o;
  logic                  s_out;

  satmag #(
    .DATA_W(DATA_W)
  ) u_satmag (
    .din(in_q),
    .mag(in_mag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_COLLECT;
      k_q      <= '0;
      min1_q   <= MAG_MAX;
      min2_q   <= MAG_MAX;
      idx1_q   <= '0;
      parity_q <= 1'b0;
      sign_q   <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      min1_q   <= min1_d;
      min2_q   <= min2_d;
      idx1_q   <= idx1_d;
      parity_q <= parity_d;
      sign_q   <= sign_d;
    end
  end

  // Next-state and accumulator update.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    min1_d   = min1_q;
    min2_d   = min2_q;
    idx1_d   = idx1_q;
    parity_d = parity_q;
    sign_d   = sign_q;

    collect  = (state_q == ST_COLLECT);
    emit     = (state_q == ST_EMIT);
    in_fire  = collect && in_valid;
    out_fire = emit && out_ready;

    if (in_fire) begin
      for (int unsigned i = 0; i < DC; i++) begin
        if (k_q == IDX_W'(i)) begin
          sign_d[i] = in_q[DATA_W-1];
        end
      end
      parity_d = parity_q ^ in_q[DATA_W-1];

      // Strict less-than keeps the earliest index on ties.
      if (in_mag < min1_q) begin
        min2_d = min1_q;
        min1_d = in_mag;
        idx1_d = k_q;
      end else if (in_mag < min2_q) begin
        min2_d = in_mag;
      end

      if (k_q == K_LAST) begin
        state_d = ST_EMIT;
        k_d     = '0;
      end else begin
        k_d = k_q + IDX_W'(1);
      end
    end

    if (out_fire) begin
      if (k_q == K_LAST) begin
        // Row complete: re-arm accumulators for the next row.
        state_d  = ST_COLLECT;
        k_d      = '0;
        min1_d   = MAG_MAX;
        min2_d   = MAG_MAX;
        idx1_d   = '0;
        parity_d = 1'b0;
        sign_d   = '0;
      end else begin
        k_d = k_q + IDX_W'(1);
      end
    end
  end

  // Output message, built only from registered row state so it is stable
  // under backpressure and independent of in_q.
  always_comb begin
    sign_sel = 1'b0;
    for (int unsigned i = 0; i < DC; i++) begin
      if (k_q == IDX_W'(i)) begin
        sign_sel = sign_q[i];
      end
    end

    m_sel = (k_q == idx1_q) ? min2_q : min1_q;
    mag_o = (m_sel > OFF) ? (m_sel - OFF) : '0;
    s_out = sign_sel ^ parity_q;

    in_ready   = (state_q == ST_COLLECT);
    out_valid  = (state_q == ST_EMIT);
    out_r      = '0;
    out_idx    = '0;
    out_parity = 1'b0;
    if (state_q == ST_EMIT) begin
      out_r      = s_out ? ((~mag_o) + DATA_W'(1)) : mag_o;
      out_idx    = k_q;
      out_parity = parity_q;
    end
  end

endmodule : cnu_serial

// File: tb/tb_cnu_serial.sv
// tb_cnu_serial: directed, table-driven bench for cnu_serial.
// Two instances share stimulus: OFFSET=0 and OFFSET=1.
module tb_cnu_serial;

  typedef struct packed {
    logic [5:0][7:0] q;
    logic [5:0][7:0] r0;
    logic [5:0][7:0] r1;
    logic            par;
    logic            gap;
  } row_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_q;
  logic       out_ready;

  logic       in_ready0, out_valid0, out_parity0;
  logic [7:0] out_r0;
  logic [2:0] out_idx0;
  logic       in_ready1, out_valid1, out_parity1;
  logic [7:0] out_r1;
  logic [2:0] out_idx1;

  int total = 0;
  int bad   = 0;
  row_t rows[5];

  always #5 clk = ~clk;

  cnu_serial #(.DATA_W(8), .DC(6), .OFFSET(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_q(in_q), .out_valid(out_valid0), .out_ready(out_ready),
    .out_r(out_r0), .out_idx(out_idx0), .out_parity(out_parity0)
  );

  cnu_serial #(.DATA_W(8), .DC(6), .OFFSET(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_q(in_q), .out_valid(out_valid1), .out_ready(out_ready),
    .out_r(out_r1), .out_idx(out_idx1), .out_parity(out_parity1)
  );

  function automatic logic [5:0][7:0] p6(input int a, input int b, input int c,
                                         input int d, input int e, input int f);
    logic [5:0][7:0] v;
    v[0] = 8'(a); v[1] = 8'(b); v[2] = 8'(c);
    v[3] = 8'(d); v[4] = 8'(e); v[5] = 8'(f);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " in_ready0"},   32'(in_ready0),   32'd1);
    chk({tag, " out_valid0"},  32'(out_valid0),  32'd0);
    chk({tag, " out_r0"},      32'(out_r0),      32'd0);
    chk({tag, " out_idx0"},    32'(out_idx0),    32'd0);
    chk({tag, " out_parity0"}, 32'(out_parity0), 32'd0);
    chk({tag, " in_ready1"},   32'(in_ready1),   32'd1);
    chk({tag, " out_valid1"},  32'(out_valid1),  32'd0);
    chk({tag, " out_r1"},      32'(out_r1),      32'd0);
  endtask

  task automatic chk_out(input row_t rw, input int k);
    chk($sformatf("k%0d out_valid0", k),  32'(out_valid0),  32'd1);
    chk($sformatf("k%0d in_ready0", k),   32'(in_ready0),   32'd0);
    chk($sformatf("k%0d out_idx0", k),    32'(out_idx0),    32'(k));
    chk($sformatf("k%0d out_r0", k),      32'(out_r0),      32'(rw.r0[k]));
    chk($sformatf("k%0d out_parity0", k), 32'(out_parity0), 32'(rw.par));
    chk($sformatf("k%0d out_valid1", k),  32'(out_valid1),  32'd1);
    chk($sformatf("k%0d out_idx1", k),    32'(out_idx1),    32'(k));
    chk($sformatf("k%0d out_r1", k),      32'(out_r1),      32'(rw.r1[k]));
    chk($sformatf("k%0d out_parity1", k), 32'(out_parity1), 32'(rw.par));
  endtask

  task automatic feed(input row_t rw, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (rw.gap && k == 3) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      chk($sformatf("feed k%0d in_ready0", k), 32'(in_ready0), 32'd1);
      in_valid = 1'b1;
      in_q     = rw.q[k];
    end
  endtask

  // Emits edges 0..upto-1; ends at the negedge after the last accept.
  task automatic emit(input row_t rw, input int upto, input bit bp);
    for (int k = 0; k < upto; k++) begin
      @(negedge clk);
      // Offered inputs during EMIT must be ignored.
      in_valid = 1'b1;
      in_q     = 8'h80;
      chk_out(rw, k);
      if (bp && k == 2) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk_out(rw, k);
        end
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (upto == 6) begin
      chk("row end in_ready0",  32'(in_ready0),  32'd1);
      chk("row end out_valid0", 32'(out_valid0), 32'd0);
    end else begin
      chk_out(rw, upto);
    end
  endtask

  task automatic run_row(input row_t rw, input bit bp);
    feed(rw, 6);
    emit(rw, 6, bp);
  endtask

  initial begin
    // Basic row: min1=2 at k3, min2=3, parity 0.
    rows[0].q  = p6(5, -3, 7, -2, 9, 4);
    rows[0].r0 = p6(2, -2, 2, -3, 2, 2);
    rows[0].r1 = p6(1, -1, 1, -2, 1, 1);
    rows[0].par = 1'b0; rows[0].gap = 1'b0;
    // Ties: idx1 stays 0, min2 equals min1.
    rows[1].q  = p6(4, 4, -4, 6, 6, 6);
    rows[1].r0 = p6(-4, -4, 4, -4, -4, -4);
    rows[1].r1 = p6(-3, -3, 3, -3, -3, -3);
    rows[1].par = 1'b1; rows[1].gap = 1'b0;
    // Saturation: -128 -> magnitude 127.
    rows[2].q  = p6(-128, -128, -128, -128, -128, -128);
    rows[2].r0 = p6(-127, -127, -127, -127, -127, -127);
    rows[2].r1 = p6(-126, -126, -126, -126, -126, -126);
    rows[2].par = 1'b0; rows[2].gap = 1'b0;
    // Zero minimum: negative zero results must read as 0; offset clamps.
    rows[3].q  = p6(0, 1, -1, 5, 6, 7);
    rows[3].r0 = p6(-1, 0, 0, 0, 0, 0);
    rows[3].r1 = p6(0, 0, 0, 0, 0, 0);
    rows[3].par = 1'b1; rows[3].gap = 1'b0;
    // Mixed row with an input bubble: min1=1 at k0, min2=3.
    rows[4].q  = p6(-1, -50, 20, -128, 3, 100);
    rows[4].r0 = p6(3, 1, -1, 1, -1, -1);
    rows[4].r1 = p6(2, 0, 0, 0, 0, 0);
    rows[4].par = 1'b1; rows[4].gap = 1'b1;

    rst_n = 1'b0; in_valid = 1'b0; in_q = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_row(rows[i], (i == 0));
    end

    // Reset during COLLECT discards the partial row.
    feed(rows[2], 3);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk_idle("collect reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_row(rows[0], 1'b0);

    // Reset during EMIT at k=3.
    feed(rows[0], 6);
    emit(rows[0], 3, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_idle("emit reset");
    @(negedge clk);
    chk_idle("emit reset held");
    rst_n = 1'b1;
    run_row(rows[1], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule : tb_cnu_serial

// File: doc/cnu_serial.md
CNU_SERIAL -- requirements
Module: cnu_serial

Interface
REQ-001 Parameter DATA_W, 8, message width in two's complement; shared with the variable node stage.
REQ-002 Parameter DC, 6, check node degree: messages per check row.
REQ-003 Parameter OFFSET, 0, offset min-sum subtrahend, unsigned, less than 2^(DATA_W-1).
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  in_q carries a variable-to-check message.
REQ-007 in_ready  output  1  block accepts in_q this cycle.
REQ-008 in_q  input  DATA_W  variable-to-check message q_k, signed.
REQ-009 out_valid  output  1  out_r carries a check-to-variable message.
REQ-010 out_ready  input  1  consumer accepts out_r this cycle.
REQ-011 out_r  output  DATA_W  check-to-variable message r_k, signed.
REQ-012 out_idx  output  ceil(log2(DC))  edge index k of out_r.
REQ-013 out_parity  output  1  XOR of all DC input sign bits (row syndrome); valid while out_valid is high.

Function
REQ-014 FSM states: COLLECT, EMIT; reset state is COLLECT.
REQ-015 COLLECT: in_ready=1 and out_valid=0; an input transfer occurs on in_valid&&in_ready.
REQ-016 Per transfer, mag = |in_q|, saturated so that -2^(DATA_W-1) maps to 2^(DATA_W-1)-1.
REQ-017 Per transfer, the sign bit is stored in sign[k], where k is the input counter 0..DC-1, and is XORed into the parity accumulator.
REQ-018 Min tracking, strict less-than: if mag<min1, then min2=min1, min1=mag, idx1=k; else if mag<min2, then min2=mag; ties therefore keep the earlier idx1.
REQ-019 At the start of each row, min1 and min2 initialise to 2^(DATA_W-1)-1, and the parity and counter initialise to 0.
REQ-020 On the transfer with k=DC-1, the FSM moves to EMIT on the next edge; the first out_valid appears exactly one cycle after the last input accept.
REQ-021 EMIT: in_ready=0 and out_valid=1; outputs are issued for k=0..DC-1 in order, advancing only on out_valid&&out_ready.
REQ-022 In EMIT, m = (k==idx1) ? min2 : min1, then mag_o = max(m-OFFSET, 0).
REQ-023 In EMIT, s = sign[k] XOR parity, and out_r = s ? -mag_o : mag_o; a zero result always outputs 0.
REQ-024 While out_valid=1 and out_ready=0, out_r, out_idx and out_parity SHALL hold stable.
REQ-025 On the accept with k=DC-1, the FSM returns to COLLECT with accumulators re-initialised, ready next cycle.
REQ-026 Counter wrap: k never exceeds DC-1; no input is lost or accepted during EMIT.
REQ-027 All outputs are driven from registers or state decode; there is no combinational path from in_q to out_r.

Reset
REQ-028 rst_n low, at any time including mid-COLLECT or mid-EMIT, asynchronously forces COLLECT, k=0, min1=min2=max, idx1=0, parity=0, sign=0.
REQ-029 During and after reset: out_valid=0, out_r=0, out_idx=0, out_parity=0, in_ready=1; a partial row is discarded.

Structure
REQ-030 A shared package holds DATA_W, DC, the derived index width, the saturated-maximum constant, and the FSM state enum.
REQ-031 The sub-module satmag (abs with saturation, combinational) is instantiated once.

Verification
REQ-032 DC=6, q=5,-3,7,-2,9,4 -> r=+2,-2,+2,-3,+2,+2, out_parity=0, first out_valid one cycle after the 6th accept.
REQ-033 Ties: q=4,4,-4,6,6,6 -> idx1=0, r=-4,-4,+4,-4,-4,-4, out_parity=1.
REQ-034 Saturation: all q=-128 -> every r=-127, out_parity=0.
REQ-035 OFFSET=1 with the REQ-032 vector -> r=+1,-1,+1,-2,+1,+1; with min=0, zero clamps to 0.
REQ-036 Backpressure: hold out_ready=0 for 3 cycles at k=2 -> out_r and out_idx stay constant, in_ready stays 0, and no output is skipped.
REQ-037 Assert rst_n low mid-EMIT at k=3 -> out_valid=0 immediately, in_ready=1; the next full row decodes correctly.
